// File: rtl/blur_stream_controller.sv
// Frame sequencer in front of blurring_filter. It regenerates sop/eop from x/y
// position, repairs short frames by padding and long frames by dropping beats, and latches blur mode per frame.
module blur_stream_controller #(
  parameter int                IMG_WIDTH  = 320,
  parameter int                IMG_HEIGHT = 240,
  parameter int                DATA_W     = 12,
  parameter logic [DATA_W-1:0] PAD_VALUE  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_sop,
  input  logic              snk_eop,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [DATA_W-1:0] src_data,
  output logic              src_sop,
  output logic              src_eop,
  input  logic              is_underage,
  output logic              blur_en,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long,
  input  logic              err_clr,
  output logic [15:0]       frame_count
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAD, DROP} state_t;

  state_t          state, state_n;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            slot_free, at_origin, last, sop_pending, x_end;
  logic            load, use_pad, latch_blur, set_short, set_long;

  assign slot_free   = !src_valid || src_ready;
  assign x_end       = (x == XW'(IMG_WIDTH - 1));
  assign at_origin   = (x == '0) && (y == '0);
  assign last        = x_end && (y == YW'(IMG_HEIGHT - 1));
  assign sop_pending = snk_valid && snk_sop;
  assign frame_done  = src_valid && src_ready && src_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (load) state_n = ACTIVE;
      ACTIVE: begin
        if (sop_pending && !at_origin) state_n = PAD;
        else if (load && last)         state_n = snk_eop ? IDLE : DROP;
        else if (load && snk_eop)      state_n = PAD;
      end
      PAD:    if (load && last) state_n = IDLE;
      DROP:   if (snk_valid && (snk_sop || snk_eop)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake and control strobes; snk_ready is held low while reset is asserted.
  always_comb begin
    snk_ready  = 1'b0;
    load       = 1'b0;
    use_pad    = 1'b0;
    latch_blur = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          snk_ready  = slot_free;
          load       = snk_valid && slot_free && snk_sop;
          latch_blur = load;
        end
        ACTIVE: begin
          snk_ready = slot_free && !sop_pending;
          load      = snk_valid && slot_free && !sop_pending;
          set_short = (load && !last && snk_eop) || (sop_pending && !at_origin);
          set_long  = load && last && !snk_eop;
        end
        PAD: begin
          load    = slot_free;
          use_pad = 1'b1;
        end
        DROP:    snk_ready = !sop_pending;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      src_valid   <= 1'b0;
      src_data    <= '0;
      src_sop     <= 1'b0;
      src_eop     <= 1'b0;
      blur_en     <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (load) begin
        src_valid <= 1'b1;
        src_data  <= use_pad ? PAD_VALUE : snk_data;
        src_sop   <= at_origin;
        src_eop   <= last;
        if (last) begin
          x <= '0;
          y <= '0;
        end else if (x_end) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end else if (src_ready) begin
        src_valid <= 1'b0;
      end
      if (latch_blur) blur_en <= is_underage;
      // A same-cycle set beats err_clr.
      if (set_short)    err_short <= 1'b1;
      else if (err_clr) err_short <= 1'b0;
      if (set_long)     err_long <= 1'b1;
      else if (err_clr) err_long <= 1'b0;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_blur_stream_controller.sv
// Directed bench for blur_stream_controller with a frame-level reference model and per-cycle output compare.
module tb_blur_stream_controller;
  localparam int W = 4, H = 3, N = W * H;
  localparam logic [11:0] PADV = 12'hABC;

  logic        clk, rst_n;
  logic        snk_valid, snk_ready, snk_sop, snk_eop;
  logic [11:0] snk_data, src_data;
  logic        src_valid, src_ready, src_sop, src_eop;
  logic        is_underage, blur_en, frame_done, err_short, err_long, err_clr;
  logic [15:0] frame_count;

  blur_stream_controller #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(12), .PAD_VALUE(PADV)) dut (
    .clk(clk), .rst_n(rst_n),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .snk_sop(snk_sop), .snk_eop(snk_eop),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .src_sop(src_sop), .src_eop(src_eop),
    .is_underage(is_underage), .blur_en(blur_en), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .err_clr(err_clr),
    .frame_count(frame_count)
  );

  typedef struct {
    logic [11:0] d;
    bit          sop, eop, blur;
  } exp_t;

  exp_t        expq[$];
  logic [11:0] sd[$];
  bit          ssop[$], seop[$], sund[$];
  int          waits[$];
  int          total = 0, bad = 0;
  int          mcount = 0, nxfer = 0, npad = 0, nblur = 0;
  bit          m_short = 0, m_long = 0, bp = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Frame-level reference: split the stimulus into frames and derive the repaired output stream.
  task automatic model();
    int   n, i, j, k;
    bit   ended, b;
    exp_t e;
    n = sd.size();
    i = 0;
    while (i < n) begin
      if (!ssop[i]) begin
        i++;
        continue;
      end
      b = sund[i]; k = 0; j = i; ended = 0;
      while (k < N && j < n && !ended) begin
        if (k > 0 && ssop[j]) break;
        e.d = sd[j]; e.sop = (k == 0); e.eop = (k == N - 1); e.blur = b;
        expq.push_back(e);
        ended = seop[j]; j++; k++;
      end
      if (k < N) begin
        m_short = 1;
        for (; k < N; k++) begin
          e.d = PADV; e.sop = 0; e.eop = (k == N - 1); e.blur = b;
          expq.push_back(e);
        end
      end else if (!ended) begin
        m_long = 1;
        while (j < n && !ssop[j]) begin
          j++;
          if (seop[j-1]) break;
        end
      end
      i = j;
    end
  endtask

  task automatic add(input logic [11:0] d, input bit s, input bit e, input bit u);
    sd.push_back(d); ssop.push_back(s); seop.push_back(e); sund.push_back(u);
  endtask

  task automatic add_frame(input logic [11:0] base, input int len, input int eop_at, input bit u);
    for (int i = 0; i < len; i++) add(base + 12'(i), i == 0, i == eop_at, u);
  endtask

  task automatic send(input logic [11:0] d, input bit s, input bit e, input bit u);
    int w = 0;
    snk_valid = 1; snk_data = d; snk_sop = s; snk_eop = e; is_underage = u;
    forever begin
      @(negedge clk);
      if (snk_ready) break;
      w++;
      if (w > 300) begin
        total++; bad++;
        $display("FAIL send_timeout: actual=stuck required=accepted");
        break;
      end
    end
    @(posedge clk); #1;
    waits.push_back(w);
  endtask

  task automatic drain();
    int c = 0;
    while (expq.size() != 0 && c < 500) begin
      @(posedge clk); c++;
    end
    chk("drain_left", expq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run();
    model();
    waits.delete();
    for (int i = 0; i < sd.size(); i++) send(sd[i], ssop[i], seop[i], sund[i]);
    snk_valid = 0; snk_sop = 0; snk_eop = 0;
    sd.delete(); ssop.delete(); seop.delete(); sund.delete();
    drain();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      src_ready = bp ? !src_ready : 1'b1;
    end
  end

  // Output compare, sampled on the falling edge.
  initial begin
    bit          pv = 0, ps = 0, pe = 0, xfer;
    logic [11:0] pd = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
        continue;
      end
      chk("frame_count", frame_count, mcount);
      if (pv) begin
        chk("stall_valid", src_valid, 1);
        chk("stall_data", src_data, pd);
        chk("stall_sop", src_sop, ps);
        chk("stall_eop", src_eop, pe);
      end
      xfer = src_valid && src_ready;
      if (xfer) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: actual=%0h required=none", src_data);
        end else begin
          e = expq.pop_front();
          chk("src_data", src_data, e.d);
          chk("src_sop", src_sop, e.sop);
          chk("src_eop", src_eop, e.eop);
          chk("blur_en", blur_en, e.blur);
          chk("frame_done", frame_done, e.eop);
          if (e.eop) mcount++;
        end
        nxfer++;
        if (src_data == PADV) npad++;
        if (blur_en) nblur++;
      end else begin
        chk("frame_done_idle", frame_done, 0);
      end
      pv = src_valid && !src_ready; pd = src_data; ps = src_sop; pe = src_eop;
    end
  end

  initial begin
    int n0, p0, b0;
    rst_n = 0; snk_valid = 0; snk_data = 0; snk_sop = 0; snk_eop = 0;
    is_underage = 0; err_clr = 0; src_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_src_valid", src_valid, 0);
    chk("rst_snk_ready", snk_ready, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_errs", {err_short, err_long, blur_en}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // clean frame
    n0 = nxfer;
    add_frame(12'h000, N, N - 1, 0);
    run();
    chk("clean_count", frame_count, 1);
    chk("clean_beats", nxfer - n0, 12);
    chk("clean_errs", {err_short, err_long}, 0);

    // backpressure, is_underage drops mid-frame, then a frame with blur off
    bp = 1; b0 = nblur;
    for (int i = 0; i < N; i++) add(12'h010 + 12'(i), i == 0, i == N - 1, i < 5);
    add_frame(12'h020, N, N - 1, 0);
    run();
    bp = 0;
    chk("bp_blur_beats", nblur - b0, 12);
    chk("bp_count", frame_count, 3);

    // short frame then a clean one
    p0 = npad;
    add_frame(12'h100, 5, 4, 0);
    add_frame(12'h110, N, N - 1, 0);
    run();
    chk("short_sop_wait", waits[5], 7);
    chk("short_pads", npad - p0, 7);
    chk("short_err", {err_short, err_long}, {m_short, m_long});
    chk("short_err_lit", {err_short, err_long}, 2'b10);
    chk("short_count", frame_count, 5);

    // mid-frame sop at beat 6
    p0 = npad;
    add_frame(12'h200, 6, -1, 1);
    add_frame(12'h300, N, N - 1, 0);
    run();
    chk("midsop_wait", waits[6], 7);
    chk("midsop_pads", npad - p0, 6);
    chk("midsop_count", frame_count, 7);

    // long frame, then clear the sticky flags
    n0 = nxfer;
    add_frame(12'h400, 15, 14, 1);
    run();
    chk("long_beats", nxfer - n0, 12);
    chk("long_err", {err_short, err_long}, {m_short, m_long});
    chk("long_err_lit", {err_short, err_long}, 2'b11);
    chk("long_count", frame_count, 8);
    err_clr = 1;
    @(posedge clk); #1;
    err_clr = 0; m_short = 0; m_long = 0;
    chk("errclr", {err_short, err_long}, 0);

    // garbage before a frame
    n0 = nxfer;
    for (int i = 0; i < 3; i++) add(12'h500 + 12'(i), 0, i == 2, 1);
    add_frame(12'h600, N, N - 1, 0);
    run();
    chk("garbage_beats", nxfer - n0, 12);
    chk("garbage_count", frame_count, 9);

    // reset while beat 5 of a frame sits in the output register
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.d = 12'h700 + 12'(i); e.sop = (i == 0); e.eop = 0; e.blur = 1;
      expq.push_back(e);
    end
    for (int i = 0; i < 6; i++) send(12'h700 + 12'(i), i == 0, 0, 1);
    snk_valid = 0; snk_sop = 0;
    chk("prereset_left", expq.size(), 0);
    chk("prereset_valid", src_valid, 1);
    rst_n = 0; mcount = 0;
    #1;
    chk("arst_src", {src_valid, src_sop, src_eop, frame_done}, 0);
    chk("arst_data", src_data, 0);
    chk("arst_blur", blur_en, 0);
    chk("arst_count", frame_count, 0);
    chk("arst_ready", snk_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    n0 = nxfer;
    send(12'h7FF, 0, 0, 0);
    snk_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_discard", nxfer - n0, 0);
    add_frame(12'h800, N, N - 1, 0);
    run();
    chk("postrst_count", frame_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
